tx_frame_packer: RTL and testbench

//  Upstream feeder of the Tx control path (length counter / FIFO / block-token inserter). Accepts DW-granular
//  TLP beats and 8-byte DLLPs from the data link layer and packs them back-to-back into 512-bit (16-DW) beats.

---
 rtl/tx_frame_packer.sv | 203 ++++++++++++++++++++
 tb/tb_tx_frame_packer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_packer.sv
// tx_frame_packer: packs DW-granular TLP beats and 8-byte DLLPs back-to-back
// into 512-bit (16-DW) beats with per-byte STP/SDP/END markers and byte valids.
// A 32-DW staging buffer holds packed DWs; a full beat is written as soon as
// 16 DWs are staged, a partial beat after FLUSH_CYCLES cycles with no new DW.
// Optional feature macro: FRAMER_STATS_EN adds saturating tlp_cnt/dllp_cnt.
module tx_frame_packer #(
  parameter int IN_DW        = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                         pclk,
  input  logic                         reset_n,
  input  logic [32*IN_DW-1:0]          tlp_data,
  input  logic                         tlp_valid,
  input  logic                         tlp_sop,
  input  logic                         tlp_eop,
  input  logic [$clog2(IN_DW+1)-1:0]   tlp_dw_cnt,
  output logic                         tlp_ready,
  input  logic [63:0]                  dllp_data,
  input  logic                         dllp_req,
  output logic                         dllp_ack,
  input  logic                         full,
  output logic [511:0]                 data_out,
  output logic                         wr,
  output logic [63:0]                  wr_valid,
  output logic [63:0]                  STP_OUT,
  output logic [63:0]                  SDP_OUT,
  output logic [63:0]                  END_OUT,
  output logic                         protocol_err
`ifdef FRAMER_STATS_EN
  ,
  output logic [15:0]                  tlp_cnt,
  output logic [15:0]                  dllp_cnt
`endif
);

  localparam int CW = $clog2(IN_DW+1);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_IN_TLP = 1'b1;
  localparam logic [7:0] FLUSH    = 8'(FLUSH_CYCLES);
  localparam logic [5:0] TLP_LIM  = 6'(32 - IN_DW);

  logic [0:0]    r_state;
  logic [5:0]    r_fill;
  logic [7:0]    r_idle;
  logic [1023:0] r_dw;
  logic [31:0]   r_stp, r_sdp, r_end;
  logic          r_wr, r_err;
  logic [511:0]  r_data_out;
  logic [63:0]   r_wr_valid, r_stp_out, r_sdp_out, r_end_out;

  logic          w_pop_full, w_pop_part, w_pop;
  logic [5:0]    w_fill_ap;
  logic          w_dllp_take, w_tlp_acc, w_tlp_drop, w_tlp_push, w_cnt_bad, w_err;
  logic [4:0]    w_tlp_n;
  logic [5:0]    w_push_n;
  logic [4:0]    w_idx;
  logic [1023:0] w_dw_nxt;
  logic [31:0]   w_stp_nxt, w_sdp_nxt, w_end_nxt;
  logic [511:0]  w_beat_data;
  logic [63:0]   w_beat_val, w_beat_stp, w_beat_sdp, w_beat_end;

  // A pop frees space in the same cycle, so admission uses the post-pop fill.
  assign w_pop_full  = (r_fill >= 6'd16) && !full;
  assign w_pop_part  = (r_fill != 6'd0) && (r_fill < 6'd16) && (r_idle == FLUSH) && !full;
  assign w_pop       = w_pop_full || w_pop_part;
  assign w_fill_ap   = w_pop_full ? (r_fill - 6'd16) : (w_pop_part ? 6'd0 : r_fill);

  // DLLPs only slot in between TLPs and win over a sop beat in the same cycle.
  assign w_dllp_take = reset_n && dllp_req && (r_state == S_IDLE) && (w_fill_ap <= 6'd30);
  assign tlp_ready   = reset_n && (w_fill_ap <= TLP_LIM) && !((r_state == S_IDLE) && w_dllp_take);
  assign dllp_ack    = w_dllp_take;

  // A beat without sop outside a TLP is handshaken but discarded.
  assign w_tlp_acc   = tlp_valid && tlp_ready;
  assign w_tlp_drop  = (r_state == S_IDLE) && !tlp_sop;
  assign w_tlp_push  = w_tlp_acc && !w_tlp_drop;
  assign w_cnt_bad   = tlp_eop && ((tlp_dw_cnt == '0) || (tlp_dw_cnt > CW'(IN_DW)));
  assign w_tlp_n     = (tlp_eop && !w_cnt_bad) ? 5'(tlp_dw_cnt) : 5'(IN_DW);
  assign w_push_n    = w_tlp_push ? {1'b0, w_tlp_n} : (w_dllp_take ? 6'd2 : 6'd0);
  assign w_err       = w_tlp_acc && ((tlp_sop && (r_state == S_IN_TLP)) || w_tlp_drop || w_cnt_bad);

  // Next staging contents: shift out a popped beat, then append new DWs at the post-pop fill.
  always_comb begin
    w_dw_nxt  = w_pop_full ? {512'b0, r_dw[1023:512]} : r_dw;
    w_stp_nxt = w_pop_full ? {16'b0, r_stp[31:16]} : r_stp;
    w_sdp_nxt = w_pop_full ? {16'b0, r_sdp[31:16]} : r_sdp;
    w_end_nxt = w_pop_full ? {16'b0, r_end[31:16]} : r_end;
    w_idx     = w_fill_ap[4:0];
    if (w_tlp_push) begin
      for (int k = 0; k < IN_DW; k++) begin
        if (5'(k) < w_tlp_n) begin
          w_idx = w_fill_ap[4:0] + 5'(k);
          w_dw_nxt[{w_idx, 5'b0} +: 32] = tlp_data[32*k +: 32];
          w_stp_nxt[w_idx] = tlp_sop && (k == 0);
          w_sdp_nxt[w_idx] = 1'b0;
          w_end_nxt[w_idx] = tlp_eop && (5'(k) == (w_tlp_n - 5'd1));
        end
      end
    end
    if (w_dllp_take) begin
      w_idx = w_fill_ap[4:0];
      w_dw_nxt[{w_idx, 5'b0} +: 32] = dllp_data[31:0];
      w_stp_nxt[w_idx] = 1'b0;
      w_sdp_nxt[w_idx] = 1'b1;
      w_end_nxt[w_idx] = 1'b0;
      w_idx = w_fill_ap[4:0] + 5'd1;
      w_dw_nxt[{w_idx, 5'b0} +: 32] = dllp_data[63:32];
      w_stp_nxt[w_idx] = 1'b0;
      w_sdp_nxt[w_idx] = 1'b0;
      w_end_nxt[w_idx] = 1'b1;
    end
  end

  // Output beat image: staged DWs below the emit count, zeros above.
  always_comb begin
    w_beat_data = '0;
    w_beat_val  = '0;
    w_beat_stp  = '0;
    w_beat_sdp  = '0;
    w_beat_end  = '0;
    for (int d = 0; d < 16; d++) begin
      if (w_pop_full || (6'(d) < r_fill)) begin
        w_beat_data[32*d +: 32] = r_dw[32*d +: 32];
        w_beat_val[4*d +: 4]    = 4'hF;
        w_beat_stp[4*d]         = r_stp[d];
        w_beat_sdp[4*d]         = r_sdp[d];
        w_beat_end[4*d+3]       = r_end[d];
      end
    end
  end

  // Staging storage; entries at or above fill are never emitted, so no reset is needed.
  always_ff @(posedge pclk) begin
    r_dw  <= w_dw_nxt;
    r_stp <= w_stp_nxt;
    r_sdp <= w_sdp_nxt;
    r_end <= w_end_nxt;
  end

  // Control state, idle counter and registered output beat.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fill     <= 6'd0;
      r_idle     <= 8'd0;
      r_wr       <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= '0;
      r_wr_valid <= '0;
      r_stp_out  <= '0;
      r_sdp_out  <= '0;
      r_end_out  <= '0;
    end else begin
      r_fill <= w_fill_ap + w_push_n;
      if (w_push_n != 6'd0)
        r_idle <= 8'd0;
      else if (r_idle < FLUSH)
        r_idle <= r_idle + 8'd1;
      if (w_tlp_push)
        r_state <= tlp_eop ? S_IDLE : S_IN_TLP;
      r_err <= w_err;
      r_wr  <= w_pop;
      if (w_pop) begin
        r_data_out <= w_beat_data;
        r_wr_valid <= w_beat_val;
        r_stp_out  <= w_beat_stp;
        r_sdp_out  <= w_beat_sdp;
        r_end_out  <= w_beat_end;
      end
    end
  end

  assign data_out     = r_data_out;
  assign wr           = r_wr;
  assign wr_valid     = r_wr_valid;
  assign STP_OUT      = r_stp_out;
  assign SDP_OUT      = r_sdp_out;
  assign END_OUT      = r_end_out;
  assign protocol_err = r_err;

`ifdef FRAMER_STATS_EN
  logic [15:0] r_tlp_cnt, r_dllp_cnt;

  // Saturating counts of accepted eop beats and accepted DLLPs.
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      r_tlp_cnt  <= 16'd0;
      r_dllp_cnt <= 16'd0;
    end else begin
      if (w_tlp_acc && tlp_eop && (r_tlp_cnt != 16'hFFFF))
        r_tlp_cnt <= r_tlp_cnt + 16'd1;
      if (w_dllp_take && (r_dllp_cnt != 16'hFFFF))
        r_dllp_cnt <= r_dllp_cnt + 16'd1;
    end
  end

  assign tlp_cnt  = r_tlp_cnt;
  assign dllp_cnt = r_dllp_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_tx_frame_packer.sv
// Testbench for tx_frame_packer: directed scenarios plus randomized traffic,
// checked against a DW-queue reference model of the packing rules.
module tb_tx_frame_packer;
  localparam int IN_DW        = 4;
  localparam int FLUSH_CYCLES = 4;
  localparam int CW           = $clog2(IN_DW+1);

  logic                 pclk = 1'b0;
  logic                 reset_n;
  logic [32*IN_DW-1:0]  tlp_data;
  logic                 tlp_valid, tlp_sop, tlp_eop;
  logic [CW-1:0]        tlp_dw_cnt;
  logic                 tlp_ready;
  logic [63:0]          dllp_data;
  logic                 dllp_req, dllp_ack;
  logic                 full;
  logic [511:0]         data_out;
  logic                 wr;
  logic [63:0]          wr_valid, STP_OUT, SDP_OUT, END_OUT;
  logic                 protocol_err;
`ifdef FRAMER_STATS_EN
  logic [15:0]          tlp_cnt, dllp_cnt;
`endif

  tx_frame_packer #(.IN_DW(IN_DW), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .pclk(pclk), .reset_n(reset_n),
    .tlp_data(tlp_data), .tlp_valid(tlp_valid), .tlp_sop(tlp_sop), .tlp_eop(tlp_eop),
    .tlp_dw_cnt(tlp_dw_cnt), .tlp_ready(tlp_ready),
    .dllp_data(dllp_data), .dllp_req(dllp_req), .dllp_ack(dllp_ack),
    .full(full), .data_out(data_out), .wr(wr), .wr_valid(wr_valid),
    .STP_OUT(STP_OUT), .SDP_OUT(SDP_OUT), .END_OUT(END_OUT),
    .protocol_err(protocol_err)
`ifdef FRAMER_STATS_EN
    , .tlp_cnt(tlp_cnt), .dllp_cnt(dllp_cnt)
`endif
  );

  always #5 pclk = ~pclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        p;
    logic        e;
  } dw_t;

  dw_t          q[$];
  int           idle;
  bit           in_tlp;
  logic [511:0] e_data;
  logic [63:0]  e_val, e_stp, e_sdp, e_end;
  bit           acc_tlp, acc_dllp;
  int           wr_count;
  int           checks   = 0;
  int           failures = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk512("data_out", data_out, e_data);
    chk64("wr_valid", wr_valid, e_val);
    chk64("STP_OUT", STP_OUT, e_stp);
    chk64("SDP_OUT", SDP_OUT, e_sdp);
    chk64("END_OUT", END_OUT, e_end);
  endtask

  // One clock cycle: called just after a falling edge with inputs applied, returns at the next falling edge.
  task automatic tick();
    bit ewr, etake, eready, nerr, pushed, bad;
    int qa, n, cnt;
    #1;
    if (!reset_n) begin
      chk1("rst_tlp_ready", tlp_ready, 1'b0);
      chk1("rst_dllp_ack", dllp_ack, 1'b0);
      acc_tlp = 0; acc_dllp = 0;
      q.delete(); idle = 0; in_tlp = 0;
      e_data = '0; e_val = '0; e_stp = '0; e_sdp = '0; e_end = '0;
      @(posedge pclk); #1;
      chk1("rst_wr", wr, 1'b0);
      chk1("rst_protocol_err", protocol_err, 1'b0);
      chk_outputs();
      @(negedge pclk);
      return;
    end
    ewr    = !full && (q.size() >= 16 || (q.size() > 0 && idle >= FLUSH_CYCLES));
    qa     = ewr ? (q.size() >= 16 ? q.size() - 16 : 0) : q.size();
    etake  = dllp_req && !in_tlp && (qa <= 30);
    eready = (qa <= 32 - IN_DW) && !(!in_tlp && etake);
    chk1("tlp_ready", tlp_ready, eready);
    chk1("dllp_ack", dllp_ack, etake);
    if (ewr) begin
      n = (q.size() >= 16) ? 16 : q.size();
      e_data = '0; e_val = '0; e_stp = '0; e_sdp = '0; e_end = '0;
      for (int d = 0; d < n; d++) begin
        dw_t x;
        x = q.pop_front();
        e_data[32*d +: 32] = x.d;
        e_val[4*d +: 4]    = 4'hF;
        e_stp[4*d]         = x.s;
        e_sdp[4*d]         = x.p;
        e_end[4*d+3]       = x.e;
      end
    end
    acc_tlp = tlp_valid && eready;
    acc_dllp = etake;
    nerr = 0; pushed = 0;
    if (acc_tlp) begin
      bad = tlp_eop && (tlp_dw_cnt == 0 || int'(tlp_dw_cnt) > IN_DW);
      cnt = (tlp_eop && !bad) ? int'(tlp_dw_cnt) : IN_DW;
      if (bad) nerr = 1;
      if (!in_tlp && !tlp_sop) begin
        nerr = 1;
      end else begin
        if (tlp_sop && in_tlp) nerr = 1;
        for (int k = 0; k < cnt; k++)
          q.push_back('{d: tlp_data[32*k +: 32], s: tlp_sop && (k == 0), p: 1'b0, e: tlp_eop && (k == cnt - 1)});
        pushed = 1;
        in_tlp = !tlp_eop;
      end
    end
    if (acc_dllp) begin
      q.push_back('{d: dllp_data[31:0],  s: 1'b0, p: 1'b1, e: 1'b0});
      q.push_back('{d: dllp_data[63:32], s: 1'b0, p: 1'b0, e: 1'b1});
      pushed = 1;
    end
    if (pushed) idle = 0;
    else if (idle < FLUSH_CYCLES) idle++;
    @(posedge pclk); #1;
    chk1("wr", wr, ewr);
    if (wr === 1'b1) wr_count++;
    chk_outputs();
    chk1("protocol_err", protocol_err, nerr);
    @(negedge pclk);
  endtask

  task automatic send_beat(input logic [127:0] d, input bit s, input bit e, input int cnt);
    int n;
    tlp_data = d; tlp_sop = s; tlp_eop = e; tlp_dw_cnt = CW'(cnt); tlp_valid = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_tlp && n < 50);
    chk1("send_beat_accepted", acc_tlp, 1'b1);
    tlp_valid = 0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_wr(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (wr !== 1'b1 && n < limit);
  endtask

  initial begin
    int n, base, rem;
    bit first;
    reset_n = 0; tlp_data = '0; tlp_valid = 0; tlp_sop = 0; tlp_eop = 0; tlp_dw_cnt = '0;
    dllp_data = '0; dllp_req = 0; full = 0; wr_count = 0;
    q.delete(); idle = 0; in_tlp = 0;
    @(negedge pclk);
    idle_ticks(2);
    reset_n = 1;

    // Scenario 1: 10-DW TLP then idle -> single partial beat after the flush delay.
    send_beat({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 0, 1, 2);
    wait_wr(20, n);
    chki("t1_flush_delay", n, FLUSH_CYCLES + 1);
    chk64("t1_wr_valid", wr_valid, 64'hFF_FFFF_FFFF);
    chk64("t1_stp", STP_OUT, 64'h1);
    chk64("t1_end", END_OUT, 64'h1 << 39);
    idle_ticks(3);

    // Scenario 2: four back-to-back 16-DW TLPs -> exactly four full beats.
    base = wr_count;
    for (int t = 0; t < 4; t++)
      for (int b = 0; b < 4; b++)
        send_beat({$urandom, $urandom, $urandom, $urandom}, b == 0, b == 3, 4);
    idle_ticks(8);
    chki("t2_beats", wr_count - base, 4);
    chk64("t2_wr_valid", wr_valid, 64'hFFFF_FFFF_FFFF_FFFF);
    chk64("t2_stp", STP_OUT, 64'h1);
    chk64("t2_end", END_OUT, 64'h1 << 63);

    // Scenario 3: DLLP and sop beat in the same cycle -> DLLP first.
    dllp_data = {$urandom, $urandom}; dllp_req = 1;
    tlp_data = {$urandom, $urandom, $urandom, $urandom}; tlp_sop = 1; tlp_eop = 1;
    tlp_dw_cnt = CW'(4); tlp_valid = 1;
    #1;
    chk1("t3_dllp_ack", dllp_ack, 1'b1);
    chk1("t3_tlp_ready", tlp_ready, 1'b0);
    tick();
    dllp_req = 0;
    tick();
    chk1("t3_beat_accepted", acc_tlp, 1'b1);
    tlp_valid = 0;
    wait_wr(20, n);
    chk64("t3_sdp", SDP_OUT, 64'h1);
    chk64("t3_end", END_OUT, 64'h80_0080);
    chk64("t3_stp", STP_OUT, 64'h100);
    idle_ticks(3);

    // Scenario 4: downstream full during streaming -> no writes, backpressure, data intact.
    full = 1; first = 1; base = wr_count;
    tlp_data = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 20; c++) begin
      tlp_valid = 1; tlp_sop = first; tlp_eop = 0; tlp_dw_cnt = '0;
      tick();
      if (acc_tlp) begin first = 0; tlp_data = {$urandom, $urandom, $urandom, $urandom}; end
    end
    chki("t4_no_wr_while_full", wr_count - base, 0);
    #1;
    chk1("t4_ready_low", tlp_ready, 1'b0);
    full = 0;
    for (int c = 0; c < 6; c++) begin
      tlp_valid = 1; tlp_sop = 0; tlp_eop = 0;
      tick();
      if (acc_tlp) tlp_data = {$urandom, $urandom, $urandom, $urandom};
    end
    tlp_valid = 0;
    send_beat({$urandom, $urandom, $urandom, $urandom}, 0, 1, 4);
    idle_ticks(12);

    // Scenario 5: sop inside an open TLP, then reset mid-stream.
    send_beat({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0);
    chk1("t5_protocol_err", protocol_err, 1'b1);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
    tlp_valid = 1; tlp_sop = 0; tlp_data = {$urandom, $urandom, $urandom, $urandom};
    reset_n = 0;
    tick();
    chk1("t5_wr_after_reset", wr, 1'b0);
    chk512("t5_data_after_reset", data_out, 512'b0);
    chk64("t5_valid_after_reset", wr_valid, 64'b0);
    reset_n = 1; tlp_valid = 0;
    base = wr_count;
    idle_ticks(10);
    chki("t5_no_flush_after_reset", wr_count - base, 0);

    // Randomized traffic with backpressure, DLLPs and occasional framing errors.
    rem = 0;
    for (int c = 0; c < 800; c++) begin
      if (!tlp_valid && $urandom_range(0, 3) != 0) begin
        if (rem == 0) begin
          rem = $urandom_range(1, 14);
          tlp_sop = ($urandom_range(0, 19) != 0);
        end else begin
          tlp_sop = ($urandom_range(0, 29) == 0);
        end
        tlp_eop = (rem <= IN_DW);
        tlp_dw_cnt = tlp_eop ? CW'(rem) : CW'($urandom_range(0, 7));
        if (tlp_eop && $urandom_range(0, 19) == 0) tlp_dw_cnt = '0;
        tlp_data = {$urandom, $urandom, $urandom, $urandom};
        tlp_valid = 1;
      end
      if (!dllp_req && $urandom_range(0, 9) == 0) begin
        dllp_req = 1;
        dllp_data = {$urandom, $urandom};
      end
      if ($urandom_range(0, 15) == 0) full = !full;
      tick();
      if (acc_tlp) begin
        tlp_valid = 0;
        rem = (rem > IN_DW) ? rem - IN_DW : 0;
      end
      if (acc_dllp) dllp_req = 0;
    end
    full = 0;
    for (int c = 0; c < 60 && (tlp_valid || dllp_req); c++) begin
      tick();
      if (acc_tlp) tlp_valid = 0;
      if (acc_dllp) dllp_req = 0;
    end
    tlp_valid = 0; dllp_req = 0;
    idle_ticks(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
